// File: rtl/blockram_arbiter.sv
// blockram_arbiter: shares one single-port blockram (1-cycle registered read)
// between two requesters A and B with round-robin arbitration and bounded
// burst lock-in. At most one RAM access per cycle; read data returns to the
// port that issued the read one cycle after its grant.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   a_req/a_wen/a_addr/a_din    port A request (held stable until a_gnt)
//   a_gnt                       combinational grant for port A
//   a_rvalid/a_rdata            port A read return
//   b_*                         identical set for port B
//   ram_enb/ram_wen/ram_addr/ram_din  RAM command (zero when idle)
//   ram_dout                    RAM registered read data
module blockram_arbiter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 10,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_req,
  input  logic             a_wen,
  input  logic [DEPTH-1:0] a_addr,
  input  logic [WIDTH-1:0] a_din,
  output logic             a_gnt,
  output logic             a_rvalid,
  output logic [WIDTH-1:0] a_rdata,
  input  logic             b_req,
  input  logic             b_wen,
  input  logic [DEPTH-1:0] b_addr,
  input  logic [WIDTH-1:0] b_din,
  output logic             b_gnt,
  output logic             b_rvalid,
  output logic [WIDTH-1:0] b_rdata,
  output logic             ram_enb,
  output logic             ram_wen,
  output logic [DEPTH-1:0] ram_addr,
  output logic [WIDTH-1:0] ram_din,
  input  logic [WIDTH-1:0] ram_dout
);

  localparam int unsigned      CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  // last: 0 = A, 1 = B
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_a_q, rd_a_d;
  logic             rd_b_q, rd_b_d;
  logic             keep_last;
  logic             any_gnt;

  // Grant: a tie stays with the last port only while a burst is open and below its cap
  always_comb begin
    a_gnt     = 1'b0;
    b_gnt     = 1'b0;
    keep_last = (cnt_q != '0) && (cnt_q < CNT_MAX);
    if (!rst) begin
      if (a_req && b_req) begin
        if (keep_last ? last_q : ~last_q) b_gnt = 1'b1;
        else                              a_gnt = 1'b1;
      end else begin
        a_gnt = a_req;
        b_gnt = b_req;
      end
    end
  end

  // Next state: burst counter, last-granted port and read-return flags
  always_comb begin
    any_gnt = a_gnt | b_gnt;
    last_d  = last_q;
    cnt_d   = '0;
    if (any_gnt) begin
      last_d = b_gnt;
      if ((b_gnt == last_q) && (cnt_q != '0)) begin
        cnt_d = (cnt_q < CNT_MAX) ? cnt_q + CNT_W'(1) : CNT_MAX;
      end else begin
        cnt_d = CNT_W'(1);
      end
    end
    rd_a_d = a_gnt & ~a_wen;
    rd_b_d = b_gnt & ~b_wen;
  end

  // RAM command mux: zero when idle
  always_comb begin
    ram_enb  = a_gnt | b_gnt;
    ram_wen  = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (a_gnt) begin
      ram_wen  = a_wen;
      ram_addr = a_addr;
      ram_din  = a_din;
    end else if (b_gnt) begin
      ram_wen  = b_wen;
      ram_addr = b_addr;
      ram_din  = b_din;
    end
  end

  // Read return gated by reset so a read granted just before reset is dropped
  always_comb begin
    a_rvalid = rd_a_q & ~rst;
    b_rvalid = rd_b_q & ~rst;
    a_rdata  = ram_dout;
    b_rdata  = ram_dout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
      cnt_q  <= '0;
      rd_a_q <= 1'b0;
      rd_b_q <= 1'b0;
    end else begin
      last_q <= last_d;
      cnt_q  <= cnt_d;
      rd_a_q <= rd_a_d;
      rd_b_q <= rd_b_d;
    end
  end

endmodule
